// File: rtl/sha3_round_sequencer.sv
// Round scheduler for the iterative Keccak-f[1600] datapath; optional perf counters under SHA3_ROUND_SEQUENCER_PERF_EN.
// Latency: (LATENCY+1)*ROUNDS+1 clocks from acceptance to out_valid; rnd_* and out_* are registered.
// Backpressure: in_ready drops while a recirculation owns the slot or during the post-reset flush; out has none.
module sha3_round_sequencer #(
    parameter int LATENCY = 4,
    parameter int ROUNDS  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [24:0][63:0] in_state,
    output logic              rnd_valid,
    output logic [24:0][63:0] rnd_state,
    output logic [4:0]        rnd_index,
    input  logic              ret_valid,
    input  logic [24:0][63:0] ret_state,
    output logic              out_valid,
    output logic [24:0][63:0] out_state,
    output logic              err
`ifdef SHA3_ROUND_SEQUENCER_PERF_EN
    ,
    output logic [31:0]       done_count,
    output logic [31:0]       stall_count
`endif
);

    typedef struct packed {
        logic       vld;
        logic [4:0] round;
    } tag_t;

    localparam int         FW   = $clog2(LATENCY + 1);
    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    tag_t [LATENCY-1:0] tag_pipe;
    tag_t               tail;
    logic [FW-1:0]      flush_cnt;
    logic               flushing;
    logic               recirc;
    logic               finish;
    logic               accept;

    logic              rnd_valid_d;
    logic [24:0][63:0] rnd_state_d;
    logic [4:0]        rnd_index_d;
    logic              out_valid_d;
    logic [24:0][63:0] out_state_d;
    logic              err_d;

    assign tail     = tag_pipe[LATENCY-1];
    assign flushing = (flush_cnt != '0);
    assign recirc   = tail.vld && (tail.round != LAST);
    assign finish   = tail.vld && (tail.round == LAST);
    assign in_ready = !recirc && !flushing;
    assign accept   = in_valid && in_ready;

    // Recirculation wins the single issue slot; a finishing state frees it for new input.
    always_comb begin
        rnd_valid_d = 1'b0;
        rnd_state_d = rnd_state;
        rnd_index_d = rnd_index;
        out_valid_d = 1'b0;
        out_state_d = out_state;
        err_d       = err;
        if (recirc) begin
            rnd_valid_d = 1'b1;
            rnd_state_d = ret_state;
            rnd_index_d = tail.round + 5'd1;
        end else if (accept) begin
            rnd_valid_d = 1'b1;
            rnd_state_d = in_state;
            rnd_index_d = 5'd0;
        end
        if (finish) begin
            out_valid_d = 1'b1;
            out_state_d = ret_state;
        end
        if (!flushing && (ret_valid != tail.vld)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe  <= '0;
            flush_cnt <= FW'(LATENCY);
            rnd_valid <= 1'b0;
            rnd_state <= '0;
            rnd_index <= 5'd0;
            out_valid <= 1'b0;
            out_state <= '0;
            err       <= 1'b0;
        end else begin
            // The issued pass's tag rides alongside the datapath and lands on the tail with its return.
            tag_pipe[0] <= '{vld: rnd_valid, round: rnd_index};
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (flushing) begin
                flush_cnt <= flush_cnt - FW'(1);
            end
            rnd_valid <= rnd_valid_d;
            rnd_state <= rnd_state_d;
            rnd_index <= rnd_index_d;
            out_valid <= out_valid_d;
            out_state <= out_state_d;
            err       <= err_d;
        end
    end

`ifdef SHA3_ROUND_SEQUENCER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count  <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (finish) begin
                done_count <= done_count + 32'd1;
            end
            if (in_valid && !in_ready && !flushing && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha3_round_sequencer.sv
// Scoreboard bench for sha3_round_sequencer with an ideal 4-clock datapath model and directed states.
module tb_sha3_round_sequencer;

    localparam int L = 4;
    localparam int R = 24;
    localparam int P = L + 1;

    typedef logic [24:0][63:0] state_t;
    typedef struct packed { logic [4:0] idx; state_t st; } rnd_exp_t;
    typedef struct packed { int cyc; state_t st; } out_exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   in_valid = 1'b0;
    state_t in_state = '0;
    logic   in_ready;
    logic   rnd_valid;
    state_t rnd_state;
    logic [4:0] rnd_index;
    logic   ret_valid;
    state_t ret_state;
    logic   out_valid;
    state_t out_state;
    logic   err;
`ifdef SHA3_ROUND_SEQUENCER_PERF_EN
    logic [31:0] done_count;
    logic [31:0] stall_count;
`endif

    sha3_round_sequencer #(.LATENCY(L), .ROUNDS(R)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .rnd_valid(rnd_valid), .rnd_state(rnd_state), .rnd_index(rnd_index),
        .ret_valid(ret_valid), .ret_state(ret_state),
        .out_valid(out_valid), .out_state(out_state), .err(err)
`ifdef SHA3_ROUND_SEQUENCER_PERF_EN
        , .done_count(done_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int edge_cnt = 0;
    int out_seen = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Stand-in round function: any bijective mix that depends on the round index.
    function automatic state_t rf(state_t s, logic [4:0] k);
        state_t r;
        for (int i = 0; i < 25; i++)
            r[i] = {s[i][62:0], s[i][63]} ^ (64'(k) << i) ^ 64'h8000_0000_0000_0001;
        return r;
    endfunction

    function automatic state_t mk(int seed);
        state_t s;
        for (int i = 0; i < 25; i++)
            s[i] = 64'h0123_4567_89ab_cdef * 64'(seed * 25 + i + 1);
        return s;
    endfunction

    // Ideal datapath: return appears exactly L clocks after the issue; not cleared by rst.
    logic [L-1:0] dl_v = '0;
    state_t       dl_st [L];
    logic [4:0]   dl_ix [L];
    logic         inject = 1'b0;

    always @(posedge clk) begin
        dl_v     <= {dl_v[L-2:0], rnd_valid};
        dl_st[0] <= rnd_state;
        dl_ix[0] <= rnd_index;
        for (int i = 1; i < L; i++) begin
            dl_st[i] <= dl_st[i-1];
            dl_ix[i] <= dl_ix[i-1];
        end
    end

    assign ret_valid = dl_v[L-1] | inject;
    assign ret_state = rf(dl_st[L-1], dl_ix[L-1]);

    out_exp_t out_q[$];
    rnd_exp_t rnd_map[int];
    out_exp_t oe;
    rnd_exp_t re;

    task automatic chk_int(string nm, longint act, longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, edge_cnt, act, exp);
        end
    endtask

    task automatic chk_st(string nm, state_t act, state_t exp);
        int ln;
        tests_run++;
        if (act !== exp) begin
            ln = 0;
            for (int i = 24; i >= 0; i--) if (act[i] !== exp[i]) ln = i;
            tests_failed++;
            $display("FAIL %s at cycle %0d lane %0d: got %h, expected %h", nm, edge_cnt, ln, act[ln], exp[ln]);
        end
    endtask

    // Called right after a negedge; returns right after the negedge following the accepting edge.
    task automatic send(input state_t st, output int acc, output int stalls);
        state_t s;
        acc = -1;
        stalls = 0;
        in_valid = 1'b1;
        in_state = st;
        for (int n = 0; n < 400; n++) begin
            if (in_ready) begin
                acc = edge_cnt;
                s = st;
                for (int k = 0; k < R; k++) begin
                    rnd_map[acc + 1 + P * k] = '{idx: 5'(k), st: s};
                    s = rf(s, 5'(k));
                end
                out_q.push_back('{cyc: acc + P * R + 1, st: s});
                @(negedge clk);
                break;
            end
            stalls++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send timeout: in_ready never rose, got 0 expected 1");
        end
    endtask

    // Called right after a negedge.
    task automatic reset_seq(input int n);
        rst = 1'b1;
        #1;
        chk_int("reset rnd_valid", rnd_valid, 0);
        chk_int("reset rnd_index", rnd_index, 0);
        chk_int("reset out_valid", out_valid, 0);
        chk_int("reset err", err, 0);
        chk_int("reset in_ready", in_ready, 0);
        chk_st("reset rnd_state", rnd_state, '0);
        chk_st("reset out_state", out_state, '0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
        out_q.delete();
        rnd_map.delete();
        for (int i = 0; i < L; i++) begin
            chk_int("flush in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk_int("post-flush in_ready", in_ready, 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (out_q.size() == 0 && rnd_map.num() == 0) break;
            @(negedge clk);
        end
        chk_int("drain out queue", out_q.size(), 0);
        chk_int("drain rnd map", rnd_map.num(), 0);
    endtask

    int acc[6];
    int stl;
    int base;
    int seen0;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (out_valid) begin
                        out_seen++;
                        if (out_q.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("FAIL unexpected out_valid at cycle %0d: got 1 expected 0", edge_cnt);
                        end else begin
                            oe = out_q.pop_front();
                            chk_int("out cycle", edge_cnt, oe.cyc);
                            chk_st("out_state", out_state, oe.st);
                        end
                    end
                    if (rnd_valid) begin
                        if (rnd_map.exists(edge_cnt)) begin
                            re = rnd_map[edge_cnt];
                            rnd_map.delete(edge_cnt);
                            chk_int("rnd_index", rnd_index, re.idx);
                            chk_st("rnd_state", rnd_state, re.st);
                        end else begin
                            tests_run++;
                            tests_failed++;
                            $display("FAIL unexpected rnd_valid at cycle %0d: got 1 expected 0", edge_cnt);
                        end
                    end
                end
            end
        join_none

        @(negedge clk);
        reset_seq(3);

        // Single state through all rounds.
        send(mk(1), acc[0], stl);
        chk_int("single stalls", stl, 0);
        wait_drain(200);
        chk_int("single err", err, 0);

        // Five back-to-back, sixth held until the first finish frees a slot.
        reset_seq(2);
        for (int s = 0; s < 5; s++) begin
            send(mk(10 + s), acc[s], stl);
            chk_int("b2b accept cycle", acc[s] - acc[0], s);
        end
        send(mk(20), acc[5], stl);
        chk_int("sixth accept cycle", acc[5] - acc[0], 120);
        chk_int("sixth stall cycles", stl, 115);
        wait_drain(400);
        repeat (2) @(negedge clk);
        chk_int("b2b err", err, 0);
`ifdef SHA3_ROUND_SEQUENCER_PERF_EN
        chk_int("done_count", done_count, 6);
        chk_int("stall_count", stall_count, 115);
`endif

        // Reset with three states in flight: nothing may come out.
        for (int s = 0; s < 3; s++) send(mk(30 + s), acc[s], stl);
        for (int n = 0; n < 100 && edge_cnt < acc[0] + 50; n++) @(negedge clk);
        chk_int("mid-op reset cycle", edge_cnt - acc[0], 50);
        seen0 = out_seen;
        reset_seq(1);
        repeat (150) @(negedge clk);
        chk_int("no out after reset", out_seen - seen0, 0);
        chk_int("err after flush returns", err, 0);

        // Spurious return with an empty tail.
        base = edge_cnt;
        repeat (30) @(negedge clk);
        chk_int("err before spurious", err, 0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        chk_int("err after spurious", err, 1);
        repeat (9) @(negedge clk);
        chk_int("err sticky", err, 1);
        chk_int("spurious timing", edge_cnt - base, 40);
        reset_seq(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
